// File: rtl/fir_coef_ctrl.sv
// rtl/fir_coef_ctrl.sv - double-buffered run-time coefficient controller for the folded 101-tap FIR
//
// Loads a coefficient set into the inactive (shadow) bank over a valid/ready
// stream, swaps banks on the next sample strobe, then holds out_valid low
// while the FIR tap line and adder tree re-settle.
//
// Optional feature: define FIR_COEF_CTRL_CHECKSUM_EN to add coef_sum, the
// wrapping sum of the most recently activated set.
//
// Ports:
//   sys_clk     system clock, rising edge
//   reset       asynchronous active-high reset
//   sam_clk_en  one-cycle sample strobe shared with the FIR
//   wr_valid    coefficient word valid
//   wr_ready    controller accepts a word (IDLE/LOAD only)
//   wr_data     signed coefficient, sent in index order 0..NUM_COEF-1
//   wr_last     final word of a set
//   coef_bus    active bank, coefficient k at [k*WIDTH +: WIDTH]
//   bank_sel    index of the active bank
//   busy        high whenever the FSM is not IDLE
//   out_valid   FIR output is trustworthy
//   coef_sum    (checksum build only) sum of the active set
//   err_len     one-cycle pulse when a set is rejected

module fir_coef_ctrl #(
  parameter int WIDTH          = 18,
  parameter int NUM_COEF       = 51,
  parameter int PTR_W          = 6,
  parameter int SETTLE_SAMPLES = 110
) (
  input  logic                      sys_clk,
  input  logic                      reset,
  input  logic                      sam_clk_en,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic                      wr_last,
  output logic [NUM_COEF*WIDTH-1:0] coef_bus,
  output logic                      bank_sel,
  output logic                      busy,
  output logic                      out_valid,
`ifdef FIR_COEF_CTRL_CHECKSUM_EN
  output logic [WIDTH-1:0]          coef_sum,
`endif
  output logic                      err_len
);

  localparam int CNT_W = $clog2(SETTLE_SAMPLES + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_SAMPLES);
  localparam logic [PTR_W-1:0] PTR_LAST    = PTR_W'(NUM_COEF - 1);

  typedef enum logic [1:0] {IDLE, LOAD, ARMED, SETTLE} state_t;

  state_t            state;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  settle_cnt;
  logic [WIDTH-1:0]  bank0 [NUM_COEF];
  logic [WIDTH-1:0]  bank1 [NUM_COEF];
  logic              accept;

  assign wr_ready = (state == IDLE) || (state == LOAD);
  assign busy     = (state != IDLE);
  assign accept   = wr_valid && wr_ready;

  for (genvar k = 0; k < NUM_COEF; k++) begin : g_bus
    assign coef_bus[k*WIDTH +: WIDTH] = bank_sel ? bank1[k] : bank0[k];
  end

  // Shadow bank write. wr_ptr is always 0 in IDLE (reset, reject and
  // completion all clear it), so the first word of a set lands in slot 0.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_COEF; i++) begin
        bank0[i] <= '0;
        bank1[i] <= '0;
      end
    end else if (accept) begin
      if (bank_sel) bank0[wr_ptr] <= wr_data;
      else          bank1[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      bank_sel   <= 1'b0;
      out_valid  <= 1'b0;
      err_len    <= 1'b0;
      settle_cnt <= '0;
    end else begin
      err_len <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (wr_last) begin
              err_len <= 1'b1;
              wr_ptr  <= '0;
            end else begin
              wr_ptr <= PTR_W'(1);
              state  <= LOAD;
            end
          end
        end
        LOAD: begin
          if (accept) begin
            if (wr_ptr == PTR_LAST) begin
              wr_ptr <= '0;
              if (wr_last) begin
                state <= ARMED;
              end else begin
                err_len <= 1'b1;
                state   <= IDLE;
              end
            end else if (wr_last) begin
              wr_ptr  <= '0;
              err_len <= 1'b1;
              state   <= IDLE;
            end else begin
              wr_ptr <= wr_ptr + 1'b1;
            end
          end
        end
        ARMED: begin
          // Swap only on a sample boundary so the FIR never sees a mixed set.
          if (sam_clk_en) begin
            bank_sel   <= ~bank_sel;
            out_valid  <= 1'b0;
            settle_cnt <= '0;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          if (sam_clk_en) begin
            settle_cnt <= settle_cnt + 1'b1;
            if (settle_cnt + 1'b1 == SETTLE_LAST) begin
              out_valid <= 1'b1;
              state     <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FIR_COEF_CTRL_CHECKSUM_EN
  logic [WIDTH-1:0] run_sum;

  // Running sum restarts on every first word; it is only published at the
  // swap, so a rejected set never disturbs coef_sum.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      run_sum  <= '0;
      coef_sum <= '0;
    end else begin
      if (accept) run_sum <= (state == IDLE) ? wr_data : run_sum + wr_data;
      if (state == ARMED && sam_clk_en) coef_sum <= run_sum;
    end
  end
`endif

endmodule

// File: tb/tb_fir_coef_ctrl.sv
// tb/tb_fir_coef_ctrl.sv - randomized self-checking bench for fir_coef_ctrl
module tb_fir_coef_ctrl;

  localparam int W      = 18;
  localparam int N      = 51;
  localparam int BUS_W  = N * W;
  localparam int SETTLE = 110;

  logic             sys_clk = 1'b0;
  logic             reset;
  logic             sam_clk_en;
  logic             wr_valid;
  logic             wr_ready;
  logic [W-1:0]     wr_data;
  logic             wr_last;
  logic [BUS_W-1:0] coef_bus;
  logic             bank_sel;
  logic             busy;
  logic             out_valid;
  logic             err_len;
`ifdef FIR_COEF_CTRL_CHECKSUM_EN
  logic [W-1:0]     coef_sum;
`endif

  fir_coef_ctrl dut (
    .sys_clk    (sys_clk),
    .reset      (reset),
    .sam_clk_en (sam_clk_en),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_data    (wr_data),
    .wr_last    (wr_last),
    .coef_bus   (coef_bus),
    .bank_sel   (bank_sel),
    .busy       (busy),
    .out_valid  (out_valid),
`ifdef FIR_COEF_CTRL_CHECKSUM_EN
    .coef_sum   (coef_sum),
`endif
    .err_len    (err_len)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [BUS_W-1:0] got, input logic [BUS_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: two banks, the list position of the set being received,
  // a pending-swap flag and the number of strobes still to settle.
  logic [W-1:0] m_bank [2][N];
  logic         m_sel;
  logic         m_ov;
  logic         m_err;
  logic         m_pending;
  int           m_settle;
  int           m_cur_n;
  logic [W-1:0] m_run;
  logic [W-1:0] m_sum;
  int           cyc;
  int           period;

  function automatic logic m_ready();
    return !m_pending && (m_settle == 0);
  endfunction

  function automatic logic [BUS_W-1:0] m_bus();
    logic [BUS_W-1:0] b;
    for (int k = 0; k < N; k++) b[k*W +: W] = m_bank[m_sel ? 1 : 0][k];
    return b;
  endfunction

  task automatic m_reset();
    for (int k = 0; k < N; k++) begin
      m_bank[0][k] = '0;
      m_bank[1][k] = '0;
    end
    m_sel = 1'b0; m_ov = 1'b0; m_err = 1'b0; m_pending = 1'b0;
    m_settle = 0; m_cur_n = 0; m_run = '0; m_sum = '0;
  endtask

  task automatic m_edge(input logic v, input logic [W-1:0] d, input logic l, input logic s);
    m_err = 1'b0;
    if (m_pending) begin
      if (s) begin
        m_sel     = ~m_sel;
        m_ov      = 1'b0;
        m_settle  = SETTLE;
        m_pending = 1'b0;
        m_sum     = m_run;
      end
    end else if (m_settle > 0) begin
      if (s) begin
        m_settle--;
        if (m_settle == 0) m_ov = 1'b1;
      end
    end else if (v) begin
      m_bank[m_sel ? 0 : 1][m_cur_n] = d;
      m_run = (m_cur_n == 0) ? d : m_run + d;
      m_cur_n++;
      if (l || m_cur_n == N) begin
        if (l && m_cur_n == N) m_pending = 1'b1;
        else                   m_err = 1'b1;
        m_cur_n = 0;
      end
    end
  endtask

  task automatic tick(input logic v, input logic [W-1:0] d, input logic l);
    logic s;
    s = (cyc % period == 0);
    wr_valid = v; wr_data = d; wr_last = l; sam_clk_en = s;
    @(posedge sys_clk);
    m_edge(v, d, l, s);
    cyc++;
    #1;
    check_eq("bank_sel", BUS_W'(bank_sel), BUS_W'(m_sel));
    check_eq("out_valid", BUS_W'(out_valid), BUS_W'(m_ov));
    check_eq("err_len", BUS_W'(err_len), BUS_W'(m_err));
    check_eq("wr_ready", BUS_W'(wr_ready), BUS_W'(m_ready()));
    check_eq("busy", BUS_W'(busy), BUS_W'(!m_ready() || m_cur_n > 0));
    check_eq("coef_bus", coef_bus, m_bus());
`ifdef FIR_COEF_CTRL_CHECKSUM_EN
    check_eq("coef_sum", BUS_W'(coef_sum), BUS_W'(m_sum));
`endif
  endtask

  // Send n words; last_at < 0 means no wr_last. Words wait for the model's
  // ready, and are offered (valid high) while the controller is busy.
  task automatic send_set(input int n, input int last_at, input bit gaps, input bit ramp);
    for (int i = 0; i < n; i++) begin
      logic [W-1:0] d;
      int guard;
      d = ramp ? W'(i + 1) : W'($urandom);
      guard = 0;
      while (1) begin
        logic v, r;
        v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
        r = m_ready();
        tick(v, d, (i == last_at));
        if (v && r) break;
        guard++;
        if (guard > 3000) begin
          check_eq("send_bound", BUS_W'(guard), BUS_W'(3000));
          break;
        end
      end
    end
  endtask

  task automatic wait_idle(input bit offer);
    int guard;
    guard = 0;
    while (!m_ready() && guard <= 3000) begin
      tick(offer ? 1'($urandom_range(0, 1)) : 1'b0, W'($urandom), 1'($urandom_range(0, 1)));
      guard++;
    end
    if (guard > 3000) check_eq("idle_bound", BUS_W'(guard), BUS_W'(3000));
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, '0, 1'b0);
  endtask

  initial begin
    logic [BUS_W-1:0] ramp_exp;
    logic sel_before;
    int guard;

    reset = 1'b1; wr_valid = 1'b0; wr_data = '0; wr_last = 1'b0; sam_clk_en = 1'b0;
    cyc = 0; period = 10;
    m_reset();
    repeat (3) @(posedge sys_clk);
    #1;
    check_eq("rst_coef_bus", coef_bus, '0);
    check_eq("rst_bank_sel", BUS_W'(bank_sel), '0);
    check_eq("rst_out_valid", BUS_W'(out_valid), '0);
    check_eq("rst_wr_ready", BUS_W'(wr_ready), BUS_W'(1));
    check_eq("rst_busy", BUS_W'(busy), '0);
    check_eq("rst_err_len", BUS_W'(err_len), '0);
    reset = 1'b0;

    // Ramp set 1..51, no gaps, offers during ARMED/SETTLE.
    send_set(N, N - 1, 1'b0, 1'b1);
    wait_idle(1'b1);
    for (int k = 0; k < N; k++) ramp_exp[k*W +: W] = W'(k + 1);
    check_eq("ramp_bus", coef_bus, ramp_exp);
    check_eq("ramp_bank_sel", BUS_W'(bank_sel), BUS_W'(1));
    check_eq("ramp_out_valid", BUS_W'(out_valid), BUS_W'(1));
`ifdef FIR_COEF_CTRL_CHECKSUM_EN
    check_eq("ramp_sum", BUS_W'(coef_sum), BUS_W'(1326));
`endif

    // Early wr_last on word 20, then a good random set.
    send_set(21, 20, 1'b1, 1'b0);
    idle(3);
    send_set(N, N - 1, 1'b1, 1'b0);
    wait_idle(1'b1);

    // 51 words with no wr_last: rejected on word 50, no swap.
    send_set(N, -1, 1'b0, 1'b0);
    idle(30);

    // Final word lands on a strobe edge: swap must wait for the next strobe.
    while (cyc % 10 != 0) idle(1);
    sel_before = m_sel;
    send_set(N, N - 1, 1'b0, 1'b0);
    check_eq("same_edge_sel", BUS_W'(bank_sel), BUS_W'(sel_before));
    check_eq("same_edge_busy", BUS_W'(busy), BUS_W'(1));
    wait_idle(1'b1);

    // Reset at strobe 50 of SETTLE, off the clock edge.
    send_set(N, N - 1, 1'b1, 1'b0);
    guard = 0;
    while (m_settle != SETTLE - 50 && guard < 3000) begin
      idle(1);
      guard++;
    end
    check_eq("settle50_reached", BUS_W'(m_settle), BUS_W'(SETTLE - 50));
    #2 reset = 1'b1;
    #1;
    m_reset();
    check_eq("async_coef_bus", coef_bus, '0);
    check_eq("async_bank_sel", BUS_W'(bank_sel), '0);
    check_eq("async_out_valid", BUS_W'(out_valid), '0);
    check_eq("async_wr_ready", BUS_W'(wr_ready), BUS_W'(1));
    @(posedge sys_clk);
    #1 reset = 1'b0;
    send_set(N, N - 1, 1'b1, 1'b0);
    wait_idle(1'b1);

    // Random strobe spacing, random sets including a reject.
    period = $urandom_range(3, 12);
    send_set(N, N - 1, 1'b1, 1'b0);
    wait_idle(1'b1);
    send_set(N, $urandom_range(0, N - 2), 1'b1, 1'b0);
    idle(5);
    send_set(N, N - 1, 1'b1, 1'b0);
    wait_idle(1'b0);
    idle(5);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fir_coef_ctrl.md
# fir_coef_ctrl

Run-time coefficient controller for the folded symmetric 101-tap FIR (51 unique coefficients, 18-bit, 0s18).
- Accepts a new coefficient set over a streaming valid/ready write port into an inactive shadow bank.
- Swaps banks atomically on a sample boundary.
- Drives the filter's parallel coefficient bus and gates the filter output as invalid while the tap line and adder tree re-settle.
- Sits between the host/config logic and the FIR datapath, on the same sys_clk / sam_clk_en domain.

## Interface
Parameters:
- WIDTH, 18, coefficient width (signed)
- NUM_COEF, 51, unique coefficients per set (index 0 = outer tap, NUM_COEF-1 = centre tap)
- PTR_W, 6, write-pointer width; 2^PTR_W must be ≥ NUM_COEF
- SETTLE_SAMPLES, 110, sam_clk_en pulses after a swap before the output is valid; covers 101 taps plus the 9-stage pipeline

Ports:
- sys_clk  in  1  system clock; all logic is rising-edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- sam_clk_en  in  1  one-cycle sample strobe, shared with the FIR
- wr_valid  in  1  coefficient word valid
- wr_ready  out  1  controller accepts a word
- wr_data  in  WIDTH  signed coefficient, sent in index order 0..NUM_COEF-1
- wr_last  in  1  marks the final word of a set
- coef_bus  out  NUM_COEF*WIDTH  active bank; coefficient k is at bits [k*WIDTH +: WIDTH]
- bank_sel  out  1  index of the active bank
- busy  out  1  high whenever state ≠ IDLE
- out_valid  out  1  FIR output is trustworthy
- err_len  out  1  one-cycle pulse when a set is rejected

## Operation
- Storage: two register banks, bank0 and bank1. coef_bus is a mux selected by the registered bank_sel. The shadow bank is the one with index ~bank_sel.
- Handshake: a word is accepted on a rising edge where wr_valid && wr_ready. wr_ready = 1 only in IDLE and LOAD.
- FSM states: IDLE, LOAD, ARMED, SETTLE.
- IDLE:
  - An accepted word is written to shadow[0] and wr_ptr becomes 1.
  - If that word also has wr_last, the set is rejected as a length error.
  - Otherwise the FSM goes to LOAD.
- LOAD: an accepted word is written to shadow[wr_ptr].
  - wr_ptr == NUM_COEF-1 with wr_last = 1: the set is complete; go to ARMED.
  - wr_ptr == NUM_COEF-1 with wr_last = 0, or wr_last = 1 at any wr_ptr < NUM_COEF-1: length error.
- Length error:
  - err_len pulses for 1 cycle and wr_ptr returns to 0; the FSM goes to IDLE.
  - The shadow bank holds partial data but is never activated.
  - The active bank, bank_sel and out_valid are unaffected.
- ARMED:
  - wr_ready = 0; words offered in this state are not accepted.
  - On the first edge with sam_clk_en = 1: bank_sel toggles, out_valid clears to 0, the settle counter clears, and the FSM goes to SETTLE.
- SETTLE:
  - wr_ready = 0.
  - Each sam_clk_en increments the counter.
  - On the edge where the counter reaches SETTLE_SAMPLES, out_valid goes to 1 and the FSM goes to IDLE.
- sam_clk_en arriving in IDLE or LOAD has no effect on the controller.
- Reset (asynchronous, including mid-LOAD/ARMED/SETTLE):
  - Values: state = IDLE, wr_ptr = 0, both banks = 0, bank_sel = 0, out_valid = 0, err_len = 0, counter = 0.
  - Outputs follow: coef_bus = 0, busy = 0, wr_ready = 1.
  - The partial set in progress is discarded. out_valid stays 0 until the first successful swap has settled.
- Coefficients are stored and forwarded unmodified; there is no arithmetic on the data path.

## Timing
- Word acceptance to shadow write: 1 cycle (registered).
- Final word accepted: state = ARMED on the next edge.
- The swap occurs on the first sam_clk_en edge seen while in ARMED, which is at least 1 cycle after the final word.
- New coef_bus is visible from the cycle after the swap edge.
- out_valid: falls at the swap edge and rises at the edge of the SETTLE_SAMPLES-th sam_clk_en counted after the swap.
- Back-to-back loads: a new set is accepted no earlier than the first IDLE cycle after SETTLE exits.
- err_len asserts on the edge after the offending word is accepted.

## Configuration
- Macro FIR_COEF_CTRL_CHECKSUM_EN.
- Defined:
  - Adds output coef_sum (WIDTH bits): the modulo-2^WIDTH wrapping sum of the accepted words of the current set.
  - The running sum clears on the first word of a set.
  - The sum is latched to coef_sum at the swap edge.
  - Reset value 0. A rejected set leaves coef_sum unchanged.
- Undefined: the port and its logic are absent; all other behaviour is identical.

## Test plan
- Reset, then load 51 words (value = index+1), wr_last on word 50, with sam_clk_en every 10 cycles:
  - ARMED follows the final word; bank_sel goes 0→1 at the next strobe.
  - coef_bus[k] = k+1 for all k.
  - out_valid rises exactly 110 strobes later.
  - With the checksum enabled, coef_sum = 1326.
- wr_last on word 20:
  - err_len pulses once; FSM returns to IDLE.
  - bank_sel, coef_bus and out_valid are unchanged.
  - A following 51-word load succeeds.
- 51 words with no wr_last: err_len pulses on word 50; no swap occurs.
- Words offered in ARMED and SETTLE are not accepted (wr_ready = 0 throughout) and the shadow bank is unchanged.
- Reset asserted mid-SETTLE (strobe 50): coef_bus = 0, bank_sel = 0, out_valid = 0 immediately, without waiting for a clock edge; a reload then works normally.
- Final word accepted on the same edge as sam_clk_en: the swap waits for the next strobe; bank_sel does not toggle on that edge.
